// File: rtl/lms_pkg.sv
// Shared types, default widths and helpers for the LMS adaptive FIR.
package lms_pkg;

    localparam int unsigned TAPS_DEF    = 8;
    localparam int unsigned X_W_DEF     = 16;
    localparam int unsigned W_W_DEF     = 16;
    localparam int unsigned E_W_DEF     = 16;
    localparam int unsigned MU_SH_DEF   = 4;
    localparam int unsigned LEAK_SH_DEF = 10;

    typedef enum logic [1:0] {StIdle, StMac, StErr, StUpd} lms_state_e;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned v = n - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return r;
    endfunction

    // Clamp a sign-extended value to the signed range of out_w bits; caller truncates.
    function automatic logic signed [63:0] sat_resize(input logic signed [63:0] v,
                                                      input int unsigned out_w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (out_w - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage

// File: rtl/lms_fir_adapt_if.sv
// Sample-in / result-out stream bundle of the LMS adaptive FIR.
interface lms_fir_adapt_if #(
    parameter int unsigned X_W = 16,
    parameter int unsigned E_W = 16
);
    logic                  in_valid;
    logic                  in_ready;
    logic signed [X_W-1:0] x_in;
    logic signed [X_W-1:0] d_in;
    logic                  adapt_en;
    logic                  out_valid;
    logic signed [X_W-1:0] y_out;
    logic signed [E_W-1:0] e_out;

    modport master (
        output in_valid, x_in, d_in, adapt_en,
        input  in_ready, out_valid, y_out, e_out
    );

    modport slave (
        input  in_valid, x_in, d_in, adapt_en,
        output in_ready, out_valid, y_out, e_out
    );
endinterface

// File: rtl/lms_tap_mac.sv
// Shared multiplier: accumulates x*w in MAC mode, saturating coefficient update in UPD mode.
// Leaky update is selected by defining LMS_LEAKAGE_EN.
module lms_tap_mac import lms_pkg::*; #(
    parameter int unsigned X_W     = X_W_DEF,
    parameter int unsigned W_W     = W_W_DEF,
    parameter int unsigned E_W     = E_W_DEF,
    parameter int unsigned AW      = 34,
    parameter int unsigned MU_SH   = MU_SH_DEF,
    parameter int unsigned LEAK_SH = LEAK_SH_DEF
) (
    input  logic                  upd,
    input  logic signed [X_W-1:0] x,
    input  logic signed [W_W-1:0] w,
    input  logic signed [E_W-1:0] e,
    input  logic signed [AW-1:0]  acc,
    output logic signed [AW-1:0]  acc_nxt,
    output logic signed [W_W-1:0] w_nxt
);
    localparam int unsigned B_W = (W_W > E_W) ? W_W : E_W;
    localparam int unsigned P_W = X_W + B_W;
    localparam int unsigned SH  = E_W - 1 + MU_SH;

    logic signed [B_W-1:0] b;
    logic signed [P_W-1:0] prod;
    logic signed [P_W-1:0] delta;
    logic signed [63:0]    w_sum;

    always_comb begin
        b       = upd ? B_W'(e) : B_W'(w);
        prod    = P_W'(x) * P_W'(b);
        delta   = prod >>> SH;
        acc_nxt = acc + AW'(prod);
`ifdef LMS_LEAKAGE_EN
        w_sum   = 64'(w) - 64'(w >>> LEAK_SH) + 64'(delta);
`else
        w_sum   = 64'(w) + 64'(delta);
`endif
        w_nxt   = W_W'(sat_resize(w_sum, W_W));
    end

endmodule

// File: rtl/lms_fir_adapt.sv
// N-tap LMS adaptive FIR sharing one multiplier across filter and update phases.
// Define LMS_LEAKAGE_EN for the leaky coefficient update; timing is unchanged.
module lms_fir_adapt import lms_pkg::*; #(
    parameter int unsigned TAPS    = TAPS_DEF,
    parameter int unsigned X_W     = X_W_DEF,
    parameter int unsigned W_W     = W_W_DEF,
    parameter int unsigned E_W     = E_W_DEF,
    parameter int unsigned MU_SH   = MU_SH_DEF,
    parameter int unsigned LEAK_SH = LEAK_SH_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    lms_fir_adapt_if.slave          s,
    input  logic [clog2(TAPS)-1:0]  coef_sel,
    output logic signed [W_W-1:0]   coef_rd
);
    localparam int unsigned IW = clog2(TAPS);
    localparam int unsigned AW = X_W + W_W + IW;

    lms_state_e            state_q;
    logic [IW-1:0]         idx_q;
    logic signed [AW-1:0]  acc_q;
    logic signed [X_W-1:0] d_q;
    logic                  adapt_q;
    logic signed [X_W-1:0] y_q;
    logic signed [E_W-1:0] e_q;
    logic                  out_valid_q;
    logic                  in_ready_q;
    logic signed [X_W-1:0] x_line_q [TAPS];
    logic signed [W_W-1:0] w_q      [TAPS];

    logic signed [X_W-1:0] y_val;
    logic signed [E_W-1:0] e_val;
    logic signed [AW-1:0]  acc_nxt;
    logic signed [W_W-1:0] w_nxt;
    logic                  last_tap;
    logic                  accept;

    always_comb begin
        y_val    = X_W'(sat_resize(64'(acc_q >>> (W_W - 1)), X_W));
        e_val    = E_W'(sat_resize(64'(d_q) - 64'(y_val), E_W));
        last_tap = (idx_q == IW'(TAPS - 1));
        accept   = (state_q == StIdle) && in_ready_q && s.in_valid;
    end

    lms_tap_mac #(
        .X_W     (X_W),
        .W_W     (W_W),
        .E_W     (E_W),
        .AW      (AW),
        .MU_SH   (MU_SH),
        .LEAK_SH (LEAK_SH)
    ) u_mac (
        .upd     (state_q == StUpd),
        .x       (x_line_q[idx_q]),
        .w       (w_q[idx_q]),
        .e       (e_q),
        .acc     (acc_q),
        .acc_nxt (acc_nxt),
        .w_nxt   (w_nxt)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            acc_q       <= '0;
            d_q         <= '0;
            adapt_q     <= 1'b0;
            y_q         <= '0;
            e_q         <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            for (int k = 0; k < TAPS; k++) begin
                x_line_q[k] <= '0;
                w_q[k]      <= '0;
            end
        end else begin
            out_valid_q <= 1'b0;
            // Ready re-asserts one cycle after returning to idle.
            in_ready_q  <= (state_q == StIdle) && !accept;
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        for (int k = TAPS - 1; k > 0; k--) begin
                            x_line_q[k] <= x_line_q[k-1];
                        end
                        x_line_q[0] <= s.x_in;
                        d_q         <= s.d_in;
                        adapt_q     <= s.adapt_en;
                        idx_q       <= '0;
                        acc_q       <= '0;
                        state_q     <= StMac;
                    end
                end
                StMac: begin
                    acc_q <= acc_nxt;
                    idx_q <= last_tap ? '0 : idx_q + 1'b1;
                    if (last_tap) state_q <= StErr;
                end
                StErr: begin
                    y_q         <= y_val;
                    e_q         <= e_val;
                    out_valid_q <= 1'b1;
                    state_q     <= adapt_q ? StUpd : StIdle;
                end
                StUpd: begin
                    w_q[idx_q] <= w_nxt;
                    idx_q      <= last_tap ? '0 : idx_q + 1'b1;
                    if (last_tap) state_q <= StIdle;
                end
            endcase
        end
    end

    assign s.in_ready  = in_ready_q;
    assign s.out_valid = out_valid_q;
    assign s.y_out     = y_q;
    assign s.e_out     = e_q;
    assign coef_rd     = w_q[coef_sel];

endmodule

// File: tb/tb_lms_fir_adapt.sv
// Self-checking bench for lms_fir_adapt (TAPS=4): vector table, scoreboard and corner cases.
module tb_lms_fir_adapt;
    localparam int unsigned TAPS  = 4;
    localparam int unsigned X_W   = 16;
    localparam int unsigned W_W   = 16;
    localparam int unsigned E_W   = 16;
    localparam int unsigned MU_SH = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lms_fir_adapt_if #(.X_W(X_W), .E_W(E_W)) bif ();
    lms_fir_adapt_if #(.X_W(X_W), .E_W(E_W)) sif ();

    logic [1:0]            coef_sel;
    logic signed [W_W-1:0] coef_rd;
    logic [1:0]            sat_sel;
    logic signed [W_W-1:0] sat_rd;

    lms_fir_adapt #(
        .TAPS(TAPS), .X_W(X_W), .W_W(W_W), .E_W(E_W), .MU_SH(MU_SH), .LEAK_SH(10)
    ) dut (
        .clk(clk), .rst_n(rst_n), .s(bif), .coef_sel(coef_sel), .coef_rd(coef_rd)
    );

    lms_fir_adapt #(
        .TAPS(TAPS), .X_W(X_W), .W_W(W_W), .E_W(E_W), .MU_SH(0), .LEAK_SH(10)
    ) dut_sat (
        .clk(clk), .rst_n(rst_n), .s(sif), .coef_sel(sat_sel), .coef_rd(sat_rd)
    );

    typedef struct {longint y; longint e;} exp_t;
    typedef struct {int x; int d; bit a; int y; int e; int w0; int w1;} vec_t;

    exp_t   sb[$];
    int     total = 0;
    int     bad = 0;
    int     n_out = 0;
    longint mx[TAPS];
    longint mw[TAPS];

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t ex;
        if (rst_n && bif.out_valid) begin
            n_out++;
            if (sb.size() == 0) begin
                check("unexpected_out_valid", 1, 0);
            end else begin
                ex = sb.pop_front();
                check("y_out", longint'(bif.y_out), ex.y);
                check("e_out", longint'(bif.e_out), ex.e);
            end
        end
    end

    function automatic longint sat16(input longint v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < TAPS; i++) begin
            mx[i] = 0;
            mw[i] = 0;
        end
    endtask

    task automatic model_step(input int x, input int d, input bit a,
                              output longint ey, output longint ee);
        longint acc;
        for (int i = TAPS - 1; i > 0; i--) mx[i] = mx[i-1];
        mx[0] = x;
        acc = 0;
        for (int i = 0; i < TAPS; i++) acc += mx[i] * mw[i];
        ey = sat16(acc >>> 15);
        ee = sat16(longint'(d) - ey);
        if (a) begin
            for (int i = 0; i < TAPS; i++) mw[i] = sat16(mw[i] + ((mx[i] * ee) >>> (15 + MU_SH)));
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_coef(input string name, input int i, input longint exp);
        coef_sel = 2'(i);
        #1;
        check(name, longint'(coef_rd), exp);
    endtask

    // Called #1 after a posedge; returns #1 after the acceptance edge.
    task automatic accept(input int x, input int d, input bit a, input bit push,
                          input longint ey, input longint ee);
        int   n;
        exp_t ex;
        n = 0;
        while (!bif.in_ready && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("accept_ready", longint'(bif.in_ready), 1);
        bif.in_valid = 1'b1;
        bif.x_in     = 16'(x);
        bif.d_in     = 16'(d);
        bif.adapt_en = a;
        if (push) begin
            ex.y = ey;
            ex.e = ee;
            sb.push_back(ex);
        end
        @(posedge clk);
        #1;
        bif.in_valid = 1'b0;
        check("ready_drop", longint'(bif.in_ready), 0);
    endtask

    task automatic wait_done(input bit a);
        int n;
        int lo;
        int lr;
        n  = 0;
        lo = -1;
        lr = -1;
        while (lr < 0 && n < 60) begin
            @(posedge clk);
            #1;
            n++;
            if (bif.out_valid && lo < 0) lo = n;
            if (bif.in_ready) lr = n;
        end
        check("out_latency", lo, TAPS + 1);
        check("ready_latency", lr, a ? 2 * TAPS + 2 : TAPS + 2);
    endtask

    initial begin
        vec_t   tbl[4];
        longint ey;
        longint ee;
        int     outs0;
        int     acc_cnt;
        int     n;
        int     xv;

        bif.in_valid = 1'b0;
        bif.x_in     = '0;
        bif.d_in     = '0;
        bif.adapt_en = 1'b0;
        sif.in_valid = 1'b0;
        sif.x_in     = '0;
        sif.d_in     = '0;
        sif.adapt_en = 1'b0;
        coef_sel     = '0;
        sat_sel      = '0;

        tbl[0] = '{16384,  8192, 1'b1,    0,  8192, 256,  0};
        tbl[1] = '{    0,     0, 1'b0,    0,     0, 256,  0};
        tbl[2] = '{16384,     0, 1'b1,  128,  -128, 252,  0};
        tbl[3] = '{-16384, 1000, 1'b1, -126,  1126, 216, 35};

        // Reset state, checked while reset is still asserted.
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", longint'(bif.in_ready), 1);
        check("rst_out_valid", longint'(bif.out_valid), 0);
        for (int i = 0; i < TAPS; i++) chk_coef($sformatf("rst_w%0d", i), i, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 4; i++) begin
            accept(tbl[i].x, tbl[i].d, tbl[i].a, 1'b1, tbl[i].y, tbl[i].e);
            wait_done(tbl[i].a);
            chk_coef($sformatf("v%0d_w0", i), 0, tbl[i].w0);
            chk_coef($sformatf("v%0d_w1", i), 1, tbl[i].w1);
        end
        chk_coef("v3_w2", 2, -4);
        chk_coef("v3_w3", 3, 35);

        // Reset during the update phase.
        accept(16384, 8192, 1'b1, 1'b1, 88, 8104);
        repeat (6) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_in_ready", longint'(bif.in_ready), 1);
        check("midrst_out_valid", longint'(bif.out_valid), 0);
        for (int i = 0; i < TAPS; i++) chk_coef($sformatf("midrst_w%0d", i), i, 0);
        rst_n = 1'b1;
        outs0 = n_out;
        repeat (12) begin
            @(posedge clk);
            #1;
        end
        check("midrst_no_out", n_out - outs0, 0);
        check("midrst_sb_empty", sb.size(), 0);
        accept(16384, 8192, 1'b1, 1'b1, 0, 8192);
        wait_done(1'b1);
        chk_coef("post_w0", 0, 256);
        for (int i = 1; i < TAPS; i++) chk_coef($sformatf("post_w%0d", i), i, 0);

        // Back-pressure: in_valid held high, new value after each acceptance.
        do_reset();
        model_reset();
        outs0        = n_out;
        acc_cnt      = 0;
        n            = 0;
        xv           = 100;
        bif.in_valid = 1'b1;
        bif.x_in     = 16'(xv);
        bif.d_in     = 16'(30000);
        bif.adapt_en = 1'b1;
        while (acc_cnt < 6 && n < 300) begin
            @(negedge clk);
            n++;
            if (bif.in_ready) begin
                exp_t ex;
                model_step(xv, 30000, 1'b1, ey, ee);
                ex.y = ey;
                ex.e = ee;
                sb.push_back(ex);
                @(posedge clk);
                #1;
                check("bp_one_accept", longint'(bif.in_ready), 0);
                acc_cnt++;
                xv += 100;
                bif.x_in = 16'(xv);
            end
        end
        bif.in_valid = 1'b0;
        n = 0;
        while (!bif.in_ready && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
        @(posedge clk);
        #1;
        check("bp_accepts", acc_cnt, 6);
        check("bp_outs", n_out - outs0, 6);
        for (int i = 0; i < TAPS; i++) chk_coef($sformatf("bp_w%0d", i), i, mw[i]);

        // Saturation on the MU_SH=0 instance.
        sif.in_valid = 1'b1;
        sif.x_in     = -16'sd32768;
        sif.d_in     = -16'sd32768;
        sif.adapt_en = 1'b1;
        @(posedge clk);
        #1;
        sif.in_valid = 1'b0;
        n = 0;
        while (!sif.out_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("sat_out_valid", longint'(sif.out_valid), 1);
        check("sat_y", longint'(sif.y_out), 0);
        check("sat_e", longint'(sif.e_out), -32768);
        n = 0;
        while (!sif.in_ready && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        sat_sel = 2'd0;
        #1;
        check("sat_w0", longint'(sat_rd), 32767);
        sat_sel = 2'd1;
        #1;
        check("sat_w1", longint'(sat_rd), 0);

        check("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1, "timeout");
    end

endmodule
